// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// stream framing constants and the word-to-byte address helper.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Instruction memory is word-organised but the write port takes byte addresses.
    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] word_idx);
        return {word_idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and loader status grouped
// as one bundle; the loader is the slave side, the host/memory the master.
interface imem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output start, rx_data, rx_valid,
        input  rx_ready, we, wa, wd, cpu_hold, done, err
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output rx_ready, we, wa, wd, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_word_packer.sv
// Assembles little-endian payload bytes into 32-bit words and keeps the
// 8-bit running checksum of every payload byte since the last clear.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o,
    output logic [7:0]  sum_o
);

    // Only the first three bytes need storing; the fourth completes the word directly.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  sum_q, sum_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
            sum_q      <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
            sum_q      <= sum_d;
        end
    end

    always_comb begin
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        sum_d        = sum_q;
        word_ready_o = 1'b0;
        if (clear_i) begin
            shift_d    = '0;
            byte_idx_d = '0;
            sum_d      = '0;
        end else if (byte_valid_i) begin
            shift_d      = {byte_i, shift_q[23:8]};
            byte_idx_d   = byte_idx_q + 2'd1;
            sum_d        = sum_q + byte_i;
            word_ready_o = (byte_idx_q == 2'(WORD_BYTES - 1));
        end
    end

    assign word_o = {byte_i, shift_q};
    assign sum_o  = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream and writes
// the assembled words into instruction memory while holding the core in reset.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_WORD = 0
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    // 17-bit so that BASE_WORD + a full 16-bit count can never wrap in the size test.
    localparam logic [16:0] MEM_WORDS = 17'(1 << ADDR_W);
    localparam logic [16:0] BASE_W17  = 17'(BASE_WORD);

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic        we_q, we_d;
    logic [31:0] wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        rx_ready;
    logic        accept;
    logic        pack_clear;
    logic        pack_valid;
    logic        word_ready;
    logic [31:0] word;
    logic [7:0]  sum;
    logic [15:0] full_count;

    assign rx_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
    assign accept     = bus.rx_valid && rx_ready;
    assign pack_clear = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                      (state_q == S_ERR));
    assign pack_valid = accept && (state_q == S_DATA);
    assign full_count = {bus.rx_data, count_q[7:0]};

    imem_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_i       (bus.rx_data),
        .word_ready_o (word_ready),
        .word_o       (word),
        .sum_o        (sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d    = S_LEN_LO;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    word_idx_d = '0;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    count_d[7:0] = bus.rx_data;
                    state_d      = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    count_d = full_count;
                    if ((BASE_W17 + {1'b0, full_count}) > MEM_WORDS) begin
                        state_d    = S_ERR;
                        err_d      = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else if (full_count == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // The write is launched from the accept of a word's last byte.
                if (word_ready) begin
                    we_d       = 1'b1;
                    wa_d       = word_to_byte_addr(32'(BASE_WORD) + {16'd0, word_idx_q});
                    wd_d       = word;
                    word_idx_d = word_idx_q + 16'd1;
                    if ((word_idx_q + 16'd1) == count_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    cpu_hold_d = 1'b0;
                    if (bus.rx_data == sum) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rx_ready = rx_ready;
    assign bus.we       = we_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven directed loads, hand-written
// timing/reset sequences and randomized loads checked against a stream model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W    = 10;
    localparam int BASE_WORD = 0;

    typedef struct {
        logic [127:0] stream;
        int           nBytes;
        int           gapPct;
        int           nWrites;
        logic [31:0]  wd0;
        logic [31:0]  wd1;
        logic         expDone;
        logic         expErr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    logic [63:0] writeQ[$];
    logic [63:0] expQ[$];
    logic [7:0]  streamQ[$];
    vec_t        vecs[5];

    always #5 clk = ~clk;

    imem_loader_if bus ();

    imem_loader #(.ADDR_W(ADDR_W), .BASE_WORD(BASE_WORD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Every write-port pulse is logged as {wa, wd}, one entry per high cycle.
    always @(negedge clk) begin
        if (bus.we === 1'b1) writeQ.push_back({bus.wa, bus.wd});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gapPct, input bit randStart);
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            bus.start = randStart ? ($urandom_range(3) == 0) : 1'b0;
            if (int'($urandom_range(99)) < gapPct) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
            end else begin
                bus.rx_valid = 1'b1;
                bus.rx_data  = b;
                if (bus.rx_ready === 1'b1) begin
                    @(posedge clk);
                    return;
                end
            end
        end
        checkOutput("sendTimeout", 64'd0, 64'd1);
    endtask

    task automatic startLoad();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("cpuHoldAfterStart", 64'(bus.cpu_hold), 64'd1);
        checkOutput("rxReadyAfterStart", 64'(bus.rx_ready), 64'd1);
    endtask

    task automatic applyStimulus(input int gapPct, input bit randStart);
        int n;
        writeQ.delete();
        startLoad();
        foreach (streamQ[i]) sendByte(streamQ[i], gapPct, randStart);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.start    = 1'b0;
        n = 0;
        while (!(bus.done === 1'b1 || bus.err === 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("endReached", 64'(bus.done | bus.err), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Reference: parse header, group payload into little-endian words, sum payload mod 256.
    task automatic buildExpected(output logic expDone, output logic expErr);
        int          cnt;
        logic [7:0]  sum;
        logic [31:0] w;
        cnt = int'(streamQ[0]) + 256 * int'(streamQ[1]);
        expQ.delete();
        sum = 8'd0;
        if (BASE_WORD + cnt > (1 << ADDR_W)) begin
            expDone = 1'b0;
            expErr  = 1'b1;
        end else begin
            for (int k = 0; k < cnt; k++) begin
                w = 32'd0;
                for (int b = 0; b < WORD_BYTES; b++) begin
                    logic [7:0] by;
                    by  = streamQ[HDR_BYTES + k * WORD_BYTES + b];
                    w   = w | (32'(by) << (8 * b));
                    sum = sum + by;
                end
                expQ.push_back({32'((BASE_WORD + k) * 4), w});
            end
            expDone = (streamQ[HDR_BYTES + cnt * WORD_BYTES] == sum);
            expErr  = !expDone;
        end
    endtask

    task automatic checkAgainstModel(input string tag);
        logic expDone, expErr;
        buildExpected(expDone, expErr);
        checkOutput({tag, "_nWrites"}, 64'(writeQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < writeQ.size(); i++)
            checkOutput({tag, "_write"}, writeQ[i], expQ[i]);
        checkOutput({tag, "_done"}, 64'(bus.done), 64'(expDone));
        checkOutput({tag, "_err"}, 64'(bus.err), 64'(expErr));
        checkOutput({tag, "_cpuHold"}, 64'(bus.cpu_hold), 64'd0);
        checkOutput({tag, "_rxReady"}, 64'(bus.rx_ready), 64'd0);
    endtask

    task automatic loadBasicStream();
        logic [127:0] s;
        s = 128'h5B_00_31_00_B3_00_62_E2_33_00_02;
        streamQ.delete();
        for (int j = 0; j < 11; j++) streamQ.push_back(s[j*8 +: 8]);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rxReady"}, 64'(bus.rx_ready), 64'd0);
        checkOutput({tag, "_we"}, 64'(bus.we), 64'd0);
        checkOutput({tag, "_wa"}, 64'(bus.wa), 64'd0);
        checkOutput({tag, "_wd"}, 64'(bus.wd), 64'd0);
        checkOutput({tag, "_cpuHold"}, 64'(bus.cpu_hold), 64'd0);
        checkOutput({tag, "_done"}, 64'(bus.done), 64'd0);
        checkOutput({tag, "_err"}, 64'(bus.err), 64'd0);
    endtask

    initial begin
        // Streams are packed with byte 0 in the least significant position.
        vecs[0] = '{128'h5B_00_31_00_B3_00_62_E2_33_00_02, 11, 0, 2, 32'h0062E233, 32'h003100B3, 1'b1, 1'b0};
        vecs[1] = '{128'h5A_00_31_00_B3_00_62_E2_33_00_02, 11, 0, 2, 32'h0062E233, 32'h003100B3, 1'b0, 1'b1};
        vecs[2] = '{128'h00_00_00, 3, 0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[3] = '{128'h04_01, 2, 0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{128'h5B_00_31_00_B3_00_62_E2_33_00_02, 11, 50, 2, 32'h0062E233, 32'h003100B3, 1'b1, 1'b0};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] table-driven loads");
        for (int i = 0; i < 5; i++) begin
            streamQ.delete();
            for (int j = 0; j < vecs[i].nBytes; j++) streamQ.push_back(vecs[i].stream[j*8 +: 8]);
            applyStimulus(vecs[i].gapPct, 1'b0);
            checkOutput("tbl_nWrites", 64'(writeQ.size()), 64'(vecs[i].nWrites));
            if (vecs[i].nWrites > 0 && writeQ.size() > 0)
                checkOutput("tbl_write0", writeQ[0], {32'h0, vecs[i].wd0});
            if (vecs[i].nWrites > 1 && writeQ.size() > 1)
                checkOutput("tbl_write1", writeQ[1], {32'h4, vecs[i].wd1});
            checkOutput("tbl_done", 64'(bus.done), 64'(vecs[i].expDone));
            checkOutput("tbl_err", 64'(bus.err), 64'(vecs[i].expErr));
            checkOutput("tbl_cpuHold", 64'(bus.cpu_hold), 64'd0);
        end

        $display("[TB] oversize header timing");
        writeQ.delete();
        startLoad();
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'h04, 0, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        checkOutput("ovs_err", 64'(bus.err), 64'd1);
        checkOutput("ovs_done", 64'(bus.done), 64'd0);
        checkOutput("ovs_rxReady", 64'(bus.rx_ready), 64'd0);
        checkOutput("ovs_cpuHold", 64'(bus.cpu_hold), 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("ovs_noWrites", 64'(writeQ.size()), 64'd0);

        $display("[TB] reset during payload");
        loadBasicStream();
        writeQ.delete();
        startLoad();
        for (int i = 0; i < HDR_BYTES + 6; i++) sendByte(streamQ[i], 0, 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        checkResetOutputs("midRst");
        checkOutput("midRst_nWrites", 64'(writeQ.size()), 64'd1);
        if (writeQ.size() > 0) checkOutput("midRst_write0", writeQ[0], {32'h0, 32'h0062E233});
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1'b0);
        checkAgainstModel("afterRst");

        $display("[TB] full-memory image");
        begin
            logic [7:0] sum;
            logic [7:0] by;
            sum = 8'd0;
            streamQ.delete();
            streamQ.push_back(8'h00);
            streamQ.push_back(8'h04);
            for (int i = 0; i < 4096; i++) begin
                by  = 8'($urandom);
                sum = sum + by;
                streamQ.push_back(by);
            end
            streamQ.push_back(sum);
        end
        applyStimulus(0, 1'b0);
        checkAgainstModel("maxImage");

        $display("[TB] randomized loads");
        for (int r = 0; r < 16; r++) begin
            int         cnt;
            logic [7:0] sum;
            logic [7:0] by;
            cnt = int'($urandom_range(0, 5));
            if ($urandom_range(7) == 0) cnt = 1025 + int'($urandom_range(0, 3000));
            streamQ.delete();
            streamQ.push_back(8'(cnt));
            streamQ.push_back(8'(cnt >> 8));
            if (cnt <= 1024) begin
                sum = 8'd0;
                for (int i = 0; i < cnt * WORD_BYTES; i++) begin
                    by  = 8'($urandom);
                    sum = sum + by;
                    streamQ.push_back(by);
                end
                if ($urandom_range(3) == 0) sum = sum + 8'($urandom_range(1, 255));
                streamQ.push_back(sum);
            end
            applyStimulus(int'($urandom_range(0, 60)), 1'b1);
            checkAgainstModel("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
